// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter
//   Shares one Avalon-MM SDRAM master port between LCD scanout burst reads and
//   single-word rasterizer writes. Scanout has strict priority because an
//   underflow corrupts the panel. A write word is never abandoned once it is on
//   the bus, and a write run is capped so scanout latency stays bounded.
// Ports
//   clock, reset                 system clock, async active-high reset
//   lcd_req/lcd_address          burst request (held until lcd_grant) and start address
//   lcd_grant                    1-cycle pulse when memory accepts the burst command
//   lcd_readdata/_readdatavalid  registered pixel words returned to scanout
//   wr_req/wr_address/wr_data/
//   wr_byteenable/wr_grant       rasterizer write word and its accept strobe
//   mem_*                        Avalon-MM master towards the memory controller
module frame_buffer_arbiter #(
    parameter int ADDR_WIDTH    = 25,
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_LEN     = 8,
    parameter int MAX_WRITE_RUN = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    lcd_req,
    input  logic [ADDR_WIDTH-1:0]   lcd_address,
    output logic                    lcd_grant,
    output logic [DATA_WIDTH-1:0]   lcd_readdata,
    output logic                    lcd_readdatavalid,
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_address,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_byteenable,
    output logic                    wr_grant,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [7:0]              mem_burstcount,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_writedata,
    output logic [DATA_WIDTH/8-1:0] mem_byteenable,
    input  logic                    mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]   mem_readdata,
    input  logic                    mem_readdatavalid
);

    localparam int RUN_W = $clog2(MAX_WRITE_RUN + 1);

    typedef enum logic [1:0] {IDLE, READ_CMD, READ_DATA, WRITE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] lcd_addr_q;
    logic [7:0]            beat_cnt;
    logic [RUN_W-1:0]      run_cnt;
    logic                  last_beat;
    logic                  run_full;

    assign last_beat = mem_readdatavalid && (beat_cnt == 8'(BURST_LEN - 1));
    // The grant being taken now is the last one allowed in this run.
    assign run_full  = (run_cnt == RUN_W'(MAX_WRITE_RUN - 1));

    always_comb begin
        state_nxt      = state;
        lcd_grant      = 1'b0;
        wr_grant       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_burstcount = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        unique case (state)
            IDLE: begin
                if (lcd_req)     state_nxt = READ_CMD;
                else if (wr_req) state_nxt = WRITE;
            end
            READ_CMD: begin
                mem_read       = 1'b1;
                mem_address    = lcd_addr_q;
                mem_burstcount = 8'(BURST_LEN);
                if (!mem_waitrequest) begin
                    lcd_grant = 1'b1;
                    state_nxt = READ_DATA;
                end
            end
            READ_DATA: begin
                if (last_beat) state_nxt = IDLE;
            end
            WRITE: begin
                mem_write      = wr_req;
                mem_address    = wr_address;
                mem_writedata  = wr_data;
                mem_byteenable = wr_byteenable;
                mem_burstcount = 8'd1;
                wr_grant       = wr_req && !mem_waitrequest;
                // A stalled word (wr_req & waitrequest) stays put, even if lcd_req rises.
                if (wr_grant) begin
                    if (lcd_req || run_full) state_nxt = IDLE;
                end else if (!wr_req) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            lcd_addr_q        <= '0;
            beat_cnt          <= '0;
            run_cnt           <= '0;
            lcd_readdata      <= '0;
            lcd_readdatavalid <= 1'b0;
        end else begin
            state             <= state_nxt;
            lcd_readdatavalid <= 1'b0;
            if (state == IDLE) begin
                if (lcd_req)     lcd_addr_q <= lcd_address;
                else if (wr_req) run_cnt    <= '0;
            end
            if (lcd_grant) beat_cnt <= '0;
            // Beats outside READ_DATA (stray or left over from an abandoned burst) are dropped.
            if (state == READ_DATA && mem_readdatavalid) begin
                lcd_readdata      <= mem_readdata;
                lcd_readdatavalid <= 1'b1;
                beat_cnt          <= beat_cnt + 8'd1;
            end
            if (wr_grant) run_cnt <= run_cnt + RUN_W'(1);
        end
    end

endmodule
